// File: rtl/clk_div.sv
// Programmable clock divider: sclk = pclk/(2*N), 50% duty, plus pclk-domain
// rise/fall strobes so downstream pclk logic never needs sclk as a clock.
module clk_div #(
  parameter int NW = 6
) (
  input  logic          pclk,
  input  logic          rst_,
  input  logic [NW-1:0] N,
  output logic          sclk,
  output logic          sclk_rise,
  output logic          sclk_fall
);

  localparam logic [NW-1:0] ONE = {{(NW-1){1'b0}}, 1'b1};

  logic [NW-1:0] cnt;
  logic [NW-1:0] n_m1;
  logic          wrap;

  // N-1 is only consumed when N != 0, so the subtraction never underflows in use.
  always_comb begin
    n_m1 = N - ONE;
    wrap = (cnt >= n_m1);
  end

  always_ff @(posedge pclk) begin
    if (rst_) begin
      cnt       <= '0;
      sclk      <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else if (N == '0) begin
      cnt       <= '0;
      sclk      <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else if (wrap) begin
      // >= rather than == so a lowered N wraps immediately instead of overrunning.
      cnt       <= '0;
      sclk      <= ~sclk;
      sclk_rise <= ~sclk;
      sclk_fall <= sclk;
    end else begin
      cnt       <= cnt + ONE;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_div.sv
// Directed self-checking bench for clk_div: reset, several divide ratios,
// disable/re-enable, mid-count ratio change and mid-phase reset.
module tb_clk_div;

  localparam int NW = 6;

  logic          pclk = 1'b0;
  logic          rst_ = 1'b1;
  logic [NW-1:0] N    = '0;
  logic          sclk;
  logic          sclk_rise;
  logic          sclk_fall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] obs;
  logic [2:0] expv;

  clk_div #(.NW(NW)) dut (
    .pclk      (pclk),
    .rst_      (rst_),
    .N         (N),
    .sclk      (sclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  always #5 pclk = ~pclk;

  // Advance one pclk cycle; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge pclk);
    #1;
    obs = {sclk, sclk_rise, sclk_fall};
  endtask

  // Expected {sclk, rise, fall} k cycles after a clean start (cnt=0, sclk=0) with ratio n.
  function automatic logic [2:0] exp_at(int n, int k);
    int  ph;
    logic edge_now;
    ph       = (k / n) % 2;
    edge_now = (k % n) == 0;
    return {ph == 1, edge_now && ph == 1, edge_now && ph == 0};
  endfunction

  task automatic do_reset(int cycles);
    rst_ = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    rst_ = 1'b0;
  endtask

  task automatic test_reset();
    N = 6'd2;
    rst_ = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: got %b expected 000", i, obs);
      end
    end
    rst_ = 1'b0;
  endtask

  task automatic test_n2();
    // Continues from test_reset release: rise at 2, fall at 4, period 4.
    for (int k = 1; k <= 12; k++) begin
      step();
      expv = exp_at(2, k);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL n2 k=%0d: got %b expected %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_n1();
    N = 6'd1;
    do_reset(1);
    for (int k = 1; k <= 10; k++) begin
      step();
      expv = (k % 2 == 1) ? 3'b110 : 3'b001;
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL n1 k=%0d: got %b expected %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_n63();
    N = 6'd63;
    do_reset(1);
    for (int k = 1; k <= 260; k++) begin
      step();
      expv = exp_at(63, k);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL n63 k=%0d: got %b expected %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_disable();
    N = 6'd3;
    do_reset(1);
    for (int k = 1; k <= 4; k++) step();
    n_checks++;
    if (obs !== 3'b100) begin
      n_fail++;
      $display("FAIL disable_pre: got %b expected 100", obs);
    end
    N = 6'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (obs !== 3'b000) begin
        n_fail++;
        $display("FAIL disable_hold i=%0d: got %b expected 000", i, obs);
      end
    end
    N = 6'd3;
    for (int k = 1; k <= 12; k++) begin
      step();
      expv = exp_at(3, k);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL reenable_n3 k=%0d: got %b expected %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_n_change();
    N = 6'd10;
    do_reset(1);
    for (int k = 1; k <= 7; k++) step();
    n_checks++;
    if (obs !== 3'b000) begin
      n_fail++;
      $display("FAIL nchg_pre: got %b expected 000", obs);
    end
    N = 6'd2;
    // cnt=7 >= 1, so the toggle lands on the very next edge, then period 4.
    for (int j = 0; j <= 10; j++) begin
      step();
      expv = exp_at(2, j + 2);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL nchg j=%0d: got %b expected %b", j, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    N = 6'd4;
    do_reset(1);
    for (int k = 1; k <= 6; k++) step();
    n_checks++;
    if (obs !== 3'b100) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %b expected 100", obs);
    end
    rst_ = 1'b1;
    step();
    n_checks++;
    if (obs !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_reset: got %b expected 000", obs);
    end
    rst_ = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      expv = exp_at(4, k);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL rstmid_after k=%0d: got %b expected %b", k, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_n2();
    test_n1();
    test_n63();
    test_disable();
    test_n_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
